// File: rtl/rf_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: opcodes, FSM states
// and the default register-file geometry.
package rf_access_ctrl_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RSP  = 3'd3,
        ST_CLR  = 3'd4,
        ST_DRD  = 3'd5,
        ST_DRSP = 3'd6
    } state_t;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Command and response streams between a requester (master) and the
// register-file access controller (slave).
interface rf_access_ctrl_if
    import rf_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_addr2;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data1, rsp_data2
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data1, rsp_data2
    );

endinterface

// File: rtl/rf_access_ctrl.sv
// Command-driven initiator for the register file: single writes, dual reads,
// a bulk clear of registers 1..top and a full dump streamed over the response port.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    rf_access_ctrl_if.slave   bus,
    output logic              busy,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              we
);

    // One spare counter bit so stepping past the top address never wraps to 0.
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic              cnt_last;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [DATA_W-1:0] data_q;

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = (state != ST_IDLE);
        ra1           = '0;
        ra2           = '0;
        wa            = '0;
        wd            = '0;
        we            = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_WRITE: state_nxt = ST_WR;
                        OP_READ:  state_nxt = ST_RD;
                        OP_CLEAR: state_nxt = ST_CLR;
                        OP_DUMP:  state_nxt = ST_DRD;
                    endcase
                end
            end
            ST_WR: begin
                we        = 1'b1;
                wa        = addr1_q;
                wd        = data_q;
                state_nxt = ST_IDLE;
            end
            ST_RD: begin
                ra1       = addr1_q;
                ra2       = addr2_q;
                state_nxt = ST_RSP;
            end
            ST_RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CLR: begin
                we = 1'b1;
                wa = cnt[ADDR_W-1:0];
                if (cnt_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRD: begin
                ra1       = cnt[ADDR_W-1:0];
                state_nxt = ST_DRSP;
            end
            ST_DRSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = cnt_last ? ST_IDLE : ST_DRD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response fields only change in RD/DRD, so they stay stable through any back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            addr1_q       <= '0;
            addr2_q       <= '0;
            data_q        <= '0;
            bus.rsp_addr  <= '0;
            bus.rsp_data1 <= '0;
            bus.rsp_data2 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr1_q <= bus.cmd_addr;
                        addr2_q <= bus.cmd_addr2;
                        data_q  <= bus.cmd_data;
                        cnt     <= (bus.cmd_op == OP_CLEAR) ? CNT_ONE : '0;
                    end
                end
                ST_RD: begin
                    bus.rsp_addr  <= addr1_q;
                    bus.rsp_data1 <= rd1;
                    bus.rsp_data2 <= rd2;
                end
                ST_CLR: begin
                    cnt <= cnt + CNT_ONE;
                end
                ST_DRD: begin
                    bus.rsp_addr  <= cnt[ADDR_W-1:0];
                    bus.rsp_data1 <= rd1;
                    bus.rsp_data2 <= '0;
                end
                ST_DRSP: begin
                    if (bus.rsp_ready && !cnt_last) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: a behavioural 32x32 register file beside the controller,
// a shadow model of its contents and a queue of expected response beats.
module tb_rf_access_ctrl;
    import rf_access_ctrl_pkg::*;

    localparam int AW    = RF_ADDR_W;
    localparam int DW    = RF_DATA_W;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rf_clr;
    logic          busy;
    logic          we;
    logic [AW-1:0] ra1, ra2, wa;
    logic [DW-1:0] rd1, rd2, wd;

    logic [DW-1:0] rf    [DEPTH];
    logic [DW-1:0] model [DEPTH];
    beat_t         sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rf_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .ra1  (ra1),
        .ra2  (ra2),
        .rd1  (rd1),
        .rd2  (rd2),
        .wa   (wa),
        .wd   (wd),
        .we   (we)
    );

    // Register file: synchronous write, combinational read, register 0 hard-wired to 0.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (we && wa != '0) begin
            rf[wa] <= wd;
        end
    end
    assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
    assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns just after the edge that accepted it.
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] a2,
                            input logic [DW-1:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_addr2 = a2;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b, required 1 within 200 cycles", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_cmd(OP_WRITE, a, '0, d);
        tick();
        if (a != '0) model[a] = d;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        int n = 0;
        while (!bus.rsp_valid && n < max) begin
            tick();
            n++;
        end
        ok = (bus.rsp_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        rf_clr        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_addr2 = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick();
        tick();
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reset_cmd_ready: got %b, want 1", bus.cmd_ready);
        end
        n_cmp++;
        if ({busy, we, bus.rsp_valid} !== 3'b000) begin
            n_bad++; $display("[TB] FAIL reset_flags: busy/we/rsp_valid got %b, want 000", {busy, we, bus.rsp_valid});
        end
        n_cmp++;
        if ({ra1, ra2, wa, wd} !== '0) begin
            n_bad++; $display("[TB] FAIL reset_rf_ports: ra1=%h ra2=%h wa=%h wd=%h, want all 0", ra1, ra2, wa, wd);
        end
        n_cmp++;
        if ({bus.rsp_addr, bus.rsp_data1, bus.rsp_data2} !== '0) begin
            n_bad++; $display("[TB] FAIL reset_rsp: addr=%h d1=%h d2=%h, want all 0", bus.rsp_addr, bus.rsp_data1, bus.rsp_data2);
        end
        rf_clr = 1'b0;
        rst    = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        beat_t exp, got;
        send_cmd(OP_WRITE, AW'(5), '0, 32'hDEADBEEF);
        n_cmp++;
        if ({busy, we, wa, wd} !== {1'b1, 1'b1, AW'(5), 32'hDEADBEEF}) begin
            n_bad++; $display("[TB] FAIL write_cycle: busy=%b we=%b wa=%h wd=%h, want 1 1 05 deadbeef", busy, we, wa, wd);
        end
        tick();
        n_cmp++;
        if ({we, bus.cmd_ready} !== 2'b01) begin
            n_bad++; $display("[TB] FAIL write_done: we=%b cmd_ready=%b, want 0 1", we, bus.cmd_ready);
        end
        model[5] = 32'hDEADBEEF;

        sb.push_back('{addr: AW'(5), d1: model[5], d2: model[0]});
        send_cmd(OP_READ, AW'(5), AW'(0), '0);
        n_cmp++;
        if ({bus.rsp_valid, ra1, ra2} !== {1'b0, AW'(5), AW'(0)}) begin
            n_bad++; $display("[TB] FAIL read_rd_cycle: rsp_valid=%b ra1=%h ra2=%h, want 0 05 00", bus.rsp_valid, ra1, ra2);
        end
        tick();
        n_cmp++;
        if (bus.rsp_valid !== 1'b1) begin
            n_bad++; $display("[TB] FAIL read_latency: rsp_valid=%b, want 1", bus.rsp_valid);
        end
        exp = sb.pop_front();
        got = {bus.rsp_addr, bus.rsp_data1, bus.rsp_data2};
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("[TB] FAIL read_beat: got %h/%h/%h, want %h/%h/%h", got.addr, got.d1, got.d2, exp.addr, exp.d1, exp.d2);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            n_bad++; $display("[TB] FAIL read_done: rsp_valid=%b cmd_ready=%b, want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_addr0();
        beat_t exp, got;
        bit ok;
        send_cmd(OP_WRITE, AW'(0), '0, 32'h12345678);
        n_cmp++;
        if ({we, wa} !== {1'b1, AW'(0)}) begin
            n_bad++; $display("[TB] FAIL addr0_write: we=%b wa=%h, want 1 00", we, wa);
        end
        tick();
        n_cmp++;
        if (we !== 1'b0) begin
            n_bad++; $display("[TB] FAIL addr0_we_pulse: we=%b, want 0", we);
        end
        sb.push_back('{addr: AW'(0), d1: model[0], d2: model[0]});
        send_cmd(OP_READ, AW'(0), AW'(0), '0);
        wait_valid(4, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("[TB] FAIL addr0_rsp_timeout: rsp_valid=%b, want 1", bus.rsp_valid);
        end
        exp = sb.pop_front();
        got = {bus.rsp_addr, bus.rsp_data1, bus.rsp_data2};
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("[TB] FAIL addr0_beat: got %h/%h/%h, want %h/%h/%h", got.addr, got.d1, got.d2, exp.addr, exp.d1, exp.d2);
        end
        tick();
    endtask

    task automatic test_clear();
        beat_t exp, got;
        bit ok;
        do_write(AW'(31), 32'hFFFFFFFF);
        do_write(AW'(1), 32'h00000001);
        send_cmd(OP_CLEAR, '0, '0, '0);
        for (int i = 1; i < DEPTH; i++) begin
            n_cmp++;
            if ({busy, we, wa, wd} !== {1'b1, 1'b1, AW'(i), {DW{1'b0}}}) begin
                n_bad++; $display("[TB] FAIL clear_cycle_%0d: busy=%b we=%b wa=%h wd=%h, want 1 1 %h 0", i, busy, we, wa, wd, AW'(i));
            end
            tick();
        end
        n_cmp++;
        if ({busy, we, bus.cmd_ready} !== 3'b001) begin
            n_bad++; $display("[TB] FAIL clear_end: busy=%b we=%b cmd_ready=%b, want 0 0 1", busy, we, bus.cmd_ready);
        end
        for (int i = 1; i < DEPTH; i++) model[i] = '0;

        sb.push_back('{addr: AW'(31), d1: model[31], d2: model[1]});
        send_cmd(OP_READ, AW'(31), AW'(1), '0);
        wait_valid(4, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("[TB] FAIL clear_rsp_timeout: rsp_valid=%b, want 1", bus.rsp_valid);
        end
        exp = sb.pop_front();
        got = {bus.rsp_addr, bus.rsp_data1, bus.rsp_data2};
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("[TB] FAIL clear_readback: got %h/%h/%h, want %h/%h/%h", got.addr, got.d1, got.d2, exp.addr, exp.d1, exp.d2);
        end
        tick();
    endtask

    task automatic test_dump();
        beat_t exp, got;
        bit ok;
        for (int i = 1; i < DEPTH; i++) do_write(AW'(i), DW'(i * 32'h11));
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) sb.push_back('{addr: AW'(i), d1: model[i], d2: '0});
        send_cmd(OP_DUMP, '0, '0, '0);
        for (int b = 0; b < DEPTH; b++) begin
            wait_valid(4, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("[TB] FAIL dump_timeout_%0d: rsp_valid=%b, want 1", b, bus.rsp_valid);
            end
            exp = sb.pop_front();
            got = {bus.rsp_addr, bus.rsp_data1, bus.rsp_data2};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("[TB] FAIL dump_beat_%0d: got %h/%h/%h, want %h/%h/%h", b, got.addr, got.d1, got.d2, exp.addr, exp.d1, exp.d2);
            end
            tick();
            if (b < DEPTH - 1) begin
                n_cmp++;
                if (bus.rsp_valid !== 1'b0) begin
                    n_bad++; $display("[TB] FAIL dump_gap_%0d: rsp_valid=%b, want 0", b, bus.rsp_valid);
                end
            end
        end
        n_cmp++;
        if ({busy, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
            n_bad++; $display("[TB] FAIL dump_end: busy=%b rsp_valid=%b cmd_ready=%b, want 0 0 1", busy, bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        beat_t exp, got;
        bit ok;
        bus.rsp_ready = 1'b0;
        sb.push_back('{addr: AW'(5), d1: model[5], d2: model[6]});
        send_cmd(OP_READ, AW'(5), AW'(6), '0);
        wait_valid(4, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("[TB] FAIL bp_timeout: rsp_valid=%b, want 1", bus.rsp_valid);
        end
        exp = sb.pop_front();
        // A write is offered throughout the stall; it must wait until the beat has gone.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        bus.cmd_addr  = AW'(7);
        bus.cmd_addr2 = '0;
        bus.cmd_data  = 32'hC0FFEE07;
        for (int c = 0; c < 10; c++) begin
            got = {bus.rsp_addr, bus.rsp_data1, bus.rsp_data2};
            n_cmp++;
            if ({bus.rsp_valid, bus.cmd_ready, we} !== 3'b100 || got !== exp) begin
                n_bad++; $display("[TB] FAIL bp_hold_%0d: valid=%b ready=%b we=%b beat %h/%h/%h, want 1 0 0 %h/%h/%h",
                                  c, bus.rsp_valid, bus.cmd_ready, we, got.addr, got.d1, got.d2, exp.addr, exp.d1, exp.d2);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.cmd_ready, we} !== 3'b010) begin
            n_bad++; $display("[TB] FAIL bp_release: rsp_valid=%b cmd_ready=%b we=%b, want 0 1 0", bus.rsp_valid, bus.cmd_ready, we);
        end
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if ({we, wa, wd} !== {1'b1, AW'(7), 32'hC0FFEE07}) begin
            n_bad++; $display("[TB] FAIL bp_next_cmd: we=%b wa=%h wd=%h, want 1 07 c0ffee07", we, wa, wd);
        end
        tick();
        model[7] = 32'hC0FFEE07;
    endtask

    task automatic test_reset_mid();
        beat_t exp, got;
        bit ok;
        logic [AW-1:0] pairs [3][2];
        pairs = '{'{AW'(1), AW'(9)}, '{AW'(20), AW'(10)}, '{AW'(11), AW'(7)}};
        do_write(AW'(20), 32'h5A5A0020);
        send_cmd(OP_CLEAR, '0, '0, '0);
        for (int c = 0; c < 9; c++) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({we, busy, bus.cmd_ready} !== 3'b001) begin
            n_bad++; $display("[TB] FAIL clr_abort: we=%b busy=%b cmd_ready=%b, want 0 0 1", we, busy, bus.cmd_ready);
        end
        for (int i = 1; i < 10; i++) model[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) begin
            sb.push_back('{addr: pairs[p][0], d1: model[pairs[p][0]], d2: model[pairs[p][1]]});
            send_cmd(OP_READ, pairs[p][0], pairs[p][1], '0);
            wait_valid(4, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("[TB] FAIL abort_rsp_timeout_%0d: rsp_valid=%b, want 1", p, bus.rsp_valid);
            end
            exp = sb.pop_front();
            got = {bus.rsp_addr, bus.rsp_data1, bus.rsp_data2};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("[TB] FAIL abort_readback_%0d: got %h/%h/%h, want %h/%h/%h", p, got.addr, got.d1, got.d2, exp.addr, exp.d1, exp.d2);
            end
            tick();
        end

        bus.rsp_ready = 1'b0;
        send_cmd(OP_DUMP, '0, '0, '0);
        wait_valid(4, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("[TB] FAIL dump_abort_timeout: rsp_valid=%b, want 1", bus.rsp_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.rsp_valid, busy, we, bus.cmd_ready} !== 4'b0001) begin
            n_bad++; $display("[TB] FAIL dump_abort: rsp_valid=%b busy=%b we=%b cmd_ready=%b, want 0 0 0 1",
                              bus.rsp_valid, busy, we, bus.cmd_ready);
        end
        tick();
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr0();
        test_clear();
        test_dump();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
